// File: rtl/axi3_slave_mem.sv
// AXI3 slave backed by a word-addressed RAM, independent read and write FSMs.
// Define AXI_SLV_WRAP_BURST_EN to support WRAP bursts; otherwise WRAP is an error burst.
module axi3_slave_mem #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  AWID,
   input  logic [31:0] AWADDR,
   input  logic [3:0]  AWLEN,
   input  logic [2:0]  AWSIZE,
   input  logic [1:0]  AWBURST,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [3:0]  WID,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WLAST,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [3:0]  BID,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
   input  logic [3:0]  ARID,
   input  logic [31:0] ARADDR,
   input  logic [3:0]  ARLEN,
   input  logic [2:0]  ARSIZE,
   input  logic [1:0]  ARBURST,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [3:0]  RID,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RLAST,
   output logic        RVALID,
   input  logic        RREADY
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(DEPTH) << 2;
`ifdef AXI_SLV_WRAP_BURST_EN
   localparam logic WRAP_EN = 1'b1;
`else
   localparam logic WRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wst_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rst_t;

   function automatic logic in_range(input logic [31:0] addr);
      logic [32:0] off;
      off = {1'b0, addr} - {1'b0, BASE_ADDR};
      return !off[32] && (off[31:0] < SPAN);
   endfunction

   function automatic logic [AW-1:0] ram_idx(input logic [31:0] addr);
      return AW'((addr - BASE_ADDR) >> 2);
   endfunction

   // Whole-burst error: oversize beats, reserved burst, or an illegal/disabled WRAP.
   function automatic logic burst_err(input logic [31:0] addr, input logic [3:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
      logic wrap_ok;
      logic bad;
      wrap_ok = WRAP_EN && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15) &&
                ((addr & ((32'd1 << size) - 32'd1)) == 32'd0);
      case (burst)
         2'b00, 2'b01: bad = (size > 3'd2);
         2'b10:        bad = (size > 3'd2) || !wrap_ok;
         default:      bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] wsize;
      logic [31:0] lower;
      logic [31:0] nxt;
      logic [31:0] res;
      wsize = ({28'd0, len} + 32'd1) << size;
      lower = addr & ~(wsize - 32'd1);
      nxt   = addr + (32'd1 << size);
      case (burst)
         2'b00: res = addr;
         2'b10: res = (WRAP_EN && (nxt == lower + wsize)) ? lower : nxt;
         default: res = nxt;
      endcase
      return res;
   endfunction

   logic [31:0] r_mem [0:DEPTH-1];

   wst_t        r_wst;
   logic        r_awready, r_wready, r_bvalid;
   logic [3:0]  r_bid, r_wid, r_wlen, r_wcnt;
   logic [1:0]  r_bresp, r_wburst;
   logic [2:0]  r_wsize;
   logic [31:0] r_waddr;
   logic        r_werr, r_wburst_err;

   rst_t        r_rst;
   logic        r_arready, r_rvalid, r_rlast;
   logic [3:0]  r_rid, r_rlen, r_rcnt;
   logic [1:0]  r_rresp, r_rburst;
   logic [2:0]  r_rsize;
   logic [31:0] r_rdata, r_raddr;
   logic        r_rburst_err;

   logic          w_w_hs, w_w_inrange, w_wbeat_err, w_wen;
   logic [AW-1:0] w_widx;

   assign w_w_hs      = r_wready & WVALID;
   assign w_w_inrange = in_range(r_waddr);
   assign w_wbeat_err = r_wburst_err | ~w_w_inrange | (WID != r_wid) |
                        (WLAST != (r_wcnt == r_wlen));
   assign w_wen       = w_w_hs & ~r_wburst_err & w_w_inrange;
   assign w_widx      = ram_idx(r_waddr);

   // Write channel FSM: AW latch, data beats, then a held B response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wst        <= W_IDLE;
         r_awready    <= 1'b0;
         r_wready     <= 1'b0;
         r_bvalid     <= 1'b0;
         r_bid        <= 4'd0;
         r_bresp      <= 2'b00;
         r_wid        <= 4'd0;
         r_wlen       <= 4'd0;
         r_wcnt       <= 4'd0;
         r_wsize      <= 3'd0;
         r_wburst     <= 2'b00;
         r_waddr      <= 32'd0;
         r_werr       <= 1'b0;
         r_wburst_err <= 1'b0;
      end else begin
         case (r_wst)
            W_IDLE: begin
               if (AWVALID && r_awready) begin
                  r_wid        <= AWID;
                  r_waddr      <= AWADDR;
                  r_wlen       <= AWLEN;
                  r_wsize      <= AWSIZE;
                  r_wburst     <= AWBURST;
                  r_wburst_err <= burst_err(AWADDR, AWLEN, AWSIZE, AWBURST);
                  r_wcnt       <= 4'd0;
                  r_werr       <= 1'b0;
                  r_awready    <= 1'b0;
                  r_wready     <= 1'b1;
                  r_wst        <= W_DATA;
               end else begin
                  r_awready    <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_w_hs) begin
                  r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                  r_wcnt  <= r_wcnt + 4'd1;
                  r_werr  <= r_werr | w_wbeat_err;
                  if (r_wcnt == r_wlen) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bid    <= r_wid;
                     r_bresp  <= (r_werr | w_wbeat_err) ? 2'b10 : 2'b00;
                     r_wst    <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wst     <= W_IDLE;
               end
            end
            default: begin
               r_wst     <= W_IDLE;
               r_awready <= 1'b0;
               r_wready  <= 1'b0;
               r_bvalid  <= 1'b0;
            end
         endcase
      end
   end

   // RAM is not reset; only enabled byte lanes are written.
   always_ff @(posedge clk) begin
      if (w_wen) begin
         for (int i = 0; i < 4; i++) begin
            if (WSTRB[i]) r_mem[w_widx][8*i +: 8] <= WDATA[8*i +: 8];
         end
      end
   end

   // Beat source: AR fields while idle (first beat), latched burst state afterwards.
   logic        w_ar_hs, w_r_hs, w_rsel_berr, w_rbeat_err;
   logic [31:0] w_rsel_addr, w_rbeat_data, w_rnext;
   logic [3:0]  w_rsel_len;
   logic [2:0]  w_rsel_size;
   logic [1:0]  w_rsel_burst;

   assign w_ar_hs      = ARVALID & r_arready;
   assign w_r_hs       = RREADY & r_rvalid;
   assign w_rsel_addr  = (r_rst == R_IDLE) ? ARADDR  : r_raddr;
   assign w_rsel_len   = (r_rst == R_IDLE) ? ARLEN   : r_rlen;
   assign w_rsel_size  = (r_rst == R_IDLE) ? ARSIZE  : r_rsize;
   assign w_rsel_burst = (r_rst == R_IDLE) ? ARBURST : r_rburst;
   assign w_rsel_berr  = (r_rst == R_IDLE) ? burst_err(ARADDR, ARLEN, ARSIZE, ARBURST)
                                           : r_rburst_err;
   assign w_rbeat_err  = w_rsel_berr | ~in_range(w_rsel_addr);
   assign w_rbeat_data = w_rbeat_err ? 32'd0 : r_mem[ram_idx(w_rsel_addr)];
   assign w_rnext      = next_addr(w_rsel_addr, w_rsel_len, w_rsel_size, w_rsel_burst);

   // Read channel FSM: each accepted beat reloads the next one on the same edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rst        <= R_IDLE;
         r_arready    <= 1'b0;
         r_rvalid     <= 1'b0;
         r_rlast      <= 1'b0;
         r_rid        <= 4'd0;
         r_rdata      <= 32'd0;
         r_rresp      <= 2'b00;
         r_rlen       <= 4'd0;
         r_rcnt       <= 4'd0;
         r_rsize      <= 3'd0;
         r_rburst     <= 2'b00;
         r_raddr      <= 32'd0;
         r_rburst_err <= 1'b0;
      end else begin
         case (r_rst)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rid        <= ARID;
                  r_rlen       <= ARLEN;
                  r_rsize      <= ARSIZE;
                  r_rburst     <= ARBURST;
                  r_rburst_err <= w_rsel_berr;
                  r_raddr      <= w_rnext;
                  r_rcnt       <= 4'd0;
                  r_rdata      <= w_rbeat_data;
                  r_rresp      <= w_rbeat_err ? 2'b10 : 2'b00;
                  r_rlast      <= (ARLEN == 4'd0);
                  r_rvalid     <= 1'b1;
                  r_arready    <= 1'b0;
                  r_rst        <= R_DATA;
               end else begin
                  r_arready    <= 1'b1;
               end
            end
            R_DATA: begin
               if (w_r_hs) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_arready <= 1'b1;
                     r_rst     <= R_IDLE;
                  end else begin
                     r_rcnt  <= r_rcnt + 4'd1;
                     r_rdata <= w_rbeat_data;
                     r_rresp <= w_rbeat_err ? 2'b10 : 2'b00;
                     r_rlast <= ((r_rcnt + 4'd1) == r_rlen);
                     r_raddr <= w_rnext;
                  end
               end
            end
            default: begin
               r_rst     <= R_IDLE;
               r_rvalid  <= 1'b0;
               r_arready <= 1'b0;
            end
         endcase
      end
   end

   assign AWREADY = r_awready;
   assign WREADY  = r_wready;
   assign BVALID  = r_bvalid;
   assign BID     = r_bid;
   assign BRESP   = r_bresp;
   assign ARREADY = r_arready;
   assign RVALID  = r_rvalid;
   assign RID     = r_rid;
   assign RDATA   = r_rdata;
   assign RRESP   = r_rresp;
   assign RLAST   = r_rlast;

endmodule

// File: tb/tb_axi3_slave_mem.sv
// Scoreboard bench for axi3_slave_mem: expected B and R payloads are queued
// when a burst is issued and compared as the slave presents them.
module tb_axi3_slave_mem;

   logic        clk, resetn;
   logic [3:0]  AWID, WID, ARID, BID, RID;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [3:0]  AWLEN, ARLEN, WSTRB;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

   int compared = 0;
   int mismatched = 0;

   logic [5:0]  bq [$];   // {BID, BRESP}
   logic [38:0] rq [$];   // {RID, RDATA, RRESP, RLAST}

   axi3_slave_mem dut (
      .clk(clk), .resetn(resetn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic exp_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                        input logic last);
      rq.push_back({id, d, resp, last});
   endtask

   task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                              input logic [3:0] strb, input logic [3:0] wid, input int early,
                              input int bstall, input logic [1:0] eresp);
      int n;
      logic [7:0] exp_b;
      bq.push_back({id, eresp});
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!AWREADY && n < 50) begin @(negedge clk); n++; end
      if (!AWREADY) begin
         compared++; mismatched++;
         $display("FAIL aw_timeout: AWREADY never rose (addr %h)", addr);
      end
      @(posedge clk); #1 AWVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         WID = wid; WDATA = d0 + 32'(i); WSTRB = strb;
         WLAST = (i == int'(len)) || (i == early); WVALID = 1'b1;
         n = 0;
         @(negedge clk);
         while (!WREADY && n < 50) begin @(negedge clk); n++; end
         if (!WREADY) begin
            compared++; mismatched++;
            $display("FAIL w_timeout: WREADY low at beat %0d", i);
         end
         @(posedge clk); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
      BREADY = (bstall == 0);
      n = 0;
      @(negedge clk);
      while (!BVALID && n < 50) begin @(negedge clk); n++; end
      for (int s = 0; s <= bstall; s++) begin
         exp_b = {1'b1, 1'b0, bq[0]};
         compared++;
         if ({BVALID, AWREADY, BID, BRESP} !== exp_b) begin
            mismatched++;
            $display("FAIL b_resp: {BVALID,AWREADY,BID,BRESP} got %b expected %b (stall %0d)",
                     {BVALID, AWREADY, BID, BRESP}, exp_b, s);
         end
         if (s < bstall) begin
            @(posedge clk); #1;
            if (s == bstall - 1) BREADY = 1'b1;
            @(negedge clk);
         end
      end
      void'(bq.pop_front());
      @(posedge clk); #1 BREADY = 1'b0;
      @(negedge clk);
      compared++;
      if ({AWREADY, BVALID} !== 2'b10) begin
         mismatched++;
         $display("FAIL b_done: {AWREADY,BVALID} got %b expected 10", {AWREADY, BVALID});
      end
      @(posedge clk); #1;
   endtask

   task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit tog);
      int n, got, cyc;
      logic [38:0] e;
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ARREADY && n < 50) begin @(negedge clk); n++; end
      if (!ARREADY) begin
         compared++; mismatched++;
         $display("FAIL ar_timeout: ARREADY never rose (addr %h)", addr);
      end
      @(posedge clk); #1 ARVALID = 1'b0;
      RREADY = 1'b1;
      got = 0; cyc = 0;
      while (got <= int'(len) && cyc < 200) begin
         @(negedge clk); cyc++;
         if (RVALID) begin
            e = rq[0];
            compared++;
            if ({RID, RDATA, RRESP, RLAST} !== e) begin
               mismatched++;
               $display("FAIL r_beat: beat %0d RID %h RDATA %h RRESP %b RLAST %b expected %h %h %b %b",
                        got, RID, RDATA, RRESP, RLAST, e[38:35], e[34:3], e[2:1], e[0]);
            end
            if (RREADY) begin void'(rq.pop_front()); got++; end
         end
         @(posedge clk); #1;
         RREADY = tog ? ~RREADY : 1'b1;
      end
      RREADY = 1'b0;
      if (got <= int'(len)) begin
         compared++; mismatched++;
         $display("FAIL r_timeout: got %0d beats expected %0d", got, int'(len) + 1);
         rq.delete();
      end
      @(negedge clk);
      compared++;
      if ({RVALID, ARREADY} !== 2'b01) begin
         mismatched++;
         $display("FAIL r_done: {RVALID,ARREADY} got %b expected 01", {RVALID, ARREADY});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      AWID = 4'd0; AWADDR = 32'd0; AWLEN = 4'd0; AWSIZE = 3'd0; AWBURST = 2'b00; AWVALID = 1'b0;
      WID = 4'd0; WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARID = 4'd0; ARADDR = 32'd0; ARLEN = 4'd0; ARSIZE = 3'd0; ARBURST = 2'b00; ARVALID = 1'b0;
      RREADY = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if ({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RID, RDATA, RRESP, RLAST, RVALID} !== 51'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RID, RDATA, RRESP, RLAST, RVALID});
      end
      resetn = 1'b1;
      @(negedge clk);
      compared++;
      if ({AWREADY, ARREADY, WREADY, BVALID, RVALID} !== 5'b11000) begin
         mismatched++;
         $display("FAIL reset_release: {AWREADY,ARREADY,WREADY,BVALID,RVALID} got %b expected 11000",
                  {AWREADY, ARREADY, WREADY, BVALID, RVALID});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_incr();
      write_burst(4'd3, 32'h10, 4'd3, 3'd2, 2'b01, 32'hA0, 4'hF, 4'd3, -1, 0, 2'b00);
      for (int i = 0; i < 4; i++) exp_r(4'd5, 32'hA0 + 32'(i), 2'b00, i == 3);
      read_burst(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 1'b0);
   endtask

   task automatic test_fixed();
      for (int i = 0; i < 3; i++) exp_r(4'd1, 32'hA0, 2'b00, i == 2);
      read_burst(4'd1, 32'h10, 4'd2, 3'd2, 2'b00, 1'b0);
   endtask

   task automatic test_strobe();
      write_burst(4'd1, 32'h20, 4'd0, 3'd2, 2'b01, 32'h11223344, 4'hF, 4'd1, -1, 0, 2'b00);
      write_burst(4'd1, 32'h20, 4'd0, 3'd2, 2'b01, 32'hAABBCCDD, 4'h5, 4'd1, -1, 0, 2'b00);
      exp_r(4'd2, 32'h11BB33DD, 2'b00, 1'b1);
      read_burst(4'd2, 32'h20, 4'd0, 3'd2, 2'b01, 1'b0);
   endtask

   task automatic test_out_of_range();
      write_burst(4'd0, 32'h0, 4'd0, 3'd2, 2'b01, 32'h5A5A0000, 4'hF, 4'd0, -1, 0, 2'b00);
      exp_r(4'd6, 32'd0, 2'b10, 1'b0);
      exp_r(4'd6, 32'd0, 2'b10, 1'b1);
      read_burst(4'd6, 32'h400, 4'd1, 3'd2, 2'b01, 1'b0);
      write_burst(4'd7, 32'h400, 4'd0, 3'd2, 2'b01, 32'hDEAD0000, 4'hF, 4'd7, -1, 0, 2'b10);
      exp_r(4'd6, 32'h5A5A0000, 2'b00, 1'b1);
      read_burst(4'd6, 32'h0, 4'd0, 3'd2, 2'b01, 1'b0);
   endtask

   task automatic test_id_wlast_err();
      write_burst(4'd2, 32'h40, 4'd3, 3'd2, 2'b01, 32'hB0, 4'hF, 4'd9, -1, 0, 2'b10);
      write_burst(4'd4, 32'h40, 4'd3, 3'd2, 2'b01, 32'hB0, 4'hF, 4'd4, 1, 0, 2'b10);
      write_burst(4'd4, 32'h50, 4'd0, 3'd2, 2'b01, 32'hB8, 4'hF, 4'd4, -1, 0, 2'b00);
   endtask

   task automatic test_stall();
      write_burst(4'd8, 32'h60, 4'd7, 3'd2, 2'b01, 32'hC0, 4'hF, 4'd8, -1, 5, 2'b00);
      for (int i = 0; i < 8; i++) exp_r(4'd9, 32'hC0 + 32'(i), 2'b00, i == 7);
      read_burst(4'd9, 32'h60, 4'd7, 3'd2, 2'b01, 1'b1);
   endtask

   task automatic test_wrap();
      write_burst(4'd3, 32'h30, 4'd3, 3'd2, 2'b01, 32'hD0, 4'hF, 4'd3, -1, 0, 2'b00);
`ifdef AXI_SLV_WRAP_BURST_EN
      exp_r(4'd10, 32'hD2, 2'b00, 1'b0);
      exp_r(4'd10, 32'hD3, 2'b00, 1'b0);
      exp_r(4'd10, 32'hD0, 2'b00, 1'b0);
      exp_r(4'd10, 32'hD1, 2'b00, 1'b1);
`else
      for (int i = 0; i < 4; i++) exp_r(4'd10, 32'd0, 2'b10, i == 3);
`endif
      read_burst(4'd10, 32'h38, 4'd3, 3'd2, 2'b10, 1'b0);
   endtask

   task automatic test_burst_errors();
      exp_r(4'd11, 32'd0, 2'b10, 1'b0);
      exp_r(4'd11, 32'd0, 2'b10, 1'b1);
      read_burst(4'd11, 32'h30, 4'd1, 3'd2, 2'b11, 1'b0);
      exp_r(4'd12, 32'd0, 2'b10, 1'b1);
      read_burst(4'd12, 32'h30, 4'd0, 3'd3, 2'b01, 1'b0);
      write_burst(4'd5, 32'h30, 4'd0, 3'd3, 2'b01, 32'hEE, 4'hF, 4'd5, -1, 0, 2'b10);
      exp_r(4'd12, 32'hD0, 2'b00, 1'b1);
      read_burst(4'd12, 32'h30, 4'd0, 3'd2, 2'b01, 1'b0);
   endtask

   initial begin
      test_reset();
      test_incr();
      test_fixed();
      test_strobe();
      test_out_of_range();
      test_id_wlast_err();
      test_stall();
      test_wrap();
      test_burst_errors();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
